// File: rtl/mem_io_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_io_responder_pkg
// Purpose : Shared constants for the memory/IO responder.
//           - RAM address width
//           - I/O base address and I/O decode bits
//           - Register offsets within the I/O window
//           - A decode helper function
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package mem_io_responder_pkg;

  // RAM byte-address width (128 KB).
  localparam int c_RAM_AW = 17;

  // The I/O window lives where address bits [17:16] match the I/O base.
  localparam logic [31:0] c_IO_BASE   = 32'h0003_0000;
  localparam int          c_IO_SEL_HI = 17;
  localparam int          c_IO_SEL_LO = 16;
  localparam logic [1:0]  c_IO_SEL    = c_IO_BASE[c_IO_SEL_HI:c_IO_SEL_LO];

  // Register selects taken from mem_a[2:0].
  typedef enum logic [2:0] {
    IO_UART = 3'h0,
    IO_CNT0 = 3'h4,
    IO_CNT1 = 3'h5,
    IO_CNT2 = 3'h6,
    IO_CNT3 = 3'h7
  } io_reg_e;

  function automatic logic is_io(input logic [31:0] addr);
    return addr[c_IO_SEL_HI:c_IO_SEL_LO] == c_IO_SEL;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_io_responder_fifo.sv
`default_nettype none
// ============================================================================
// Module  : resp_byte_fifo
// Purpose : Synchronous FIFO used for the UART TX and RX byte queues.
//           Pointers carry one extra wrap bit so full and empty are told
//           apart by the MSB. A push into a full FIFO is still accepted
//           when a pop happens in the same cycle.
// Ports   : i_clk, i_rst (async, active-high)
//           i_push/i_wdata : write side
//           i_pop/o_rdata  : read side (o_rdata is the current head)
//           o_full/o_empty/o_count : status from registered pointers
// Revision: 1.0 - initial release
// ============================================================================
module resp_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [0:DEPTH-1];

  logic w_full;
  logic w_empty;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~w_empty;
  // When full, the slot being written is the head being popped this edge.
  assign w_do_push = i_push & (~w_full | w_do_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage is not reset; the pointers define which entries are valid.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr[AW-1:0]];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_wptr - r_rptr;

endmodule
`default_nettype wire

// File: rtl/mem_io_responder.sv
`default_nettype none
// ============================================================================
// Module  : mem_io_responder
// Purpose : Memory-side responder for the CPU byte bus. Models a RAM with
//           one-cycle read latency plus memory-mapped I/O at
//           mem_a[17:16]==2'b11: UART TX/RX FIFOs, cycle-counter readback
//           with a snapshot, and a sticky program-stop flag.
// Config  : IO_RX_EN - when defined, the RX FIFO and rx_* handshake exist;
//           otherwise rx_ready is 0 and reads of the UART register return 0.
// Ports   : clk_in, rst_in (async, active-high), rdy_in (bus freeze)
//           mem_a/mem_dout/mem_wr/mem_din : CPU bus
//           io_buffer_full                : TX FIFO nearly full
//           tx_data/tx_valid/tx_ready     : UART TX stream
//           rx_data/rx_valid/rx_ready     : UART RX stream
//           prog_stop, cycle_count        : status
// Revision: 1.0 - initial release
// ============================================================================
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = c_RAM_AW,
  parameter int TX_DEPTH    = 16,
  parameter int RX_DEPTH    = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        prog_stop,
  output logic [31:0] cycle_count
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam logic [TX_AW:0] c_TX_DEPTH = TX_DEPTH[TX_AW:0];
  localparam logic [TX_AW:0] c_MARGIN   = FULL_MARGIN[TX_AW:0];

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  logic                  w_io;
  logic [2:0]            w_reg;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_bus_wr;
  logic                  w_bus_rd;
  logic                  w_unused_addr;

  assign w_io          = is_io(mem_a);
  assign w_reg         = mem_a[2:0];
  assign w_idx         = mem_a[ADDR_WIDTH-1:0];
  assign w_bus_wr      = rdy_in &  mem_wr;
  assign w_bus_rd      = rdy_in & ~mem_wr;
  assign w_unused_addr = ^mem_a[31:18];

  // --------------------------------------------------------------------------
  // RAM (contents are preloaded, never reset)
  // --------------------------------------------------------------------------
  logic [7:0] r_ram [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk_in) begin
    if (w_bus_wr && !w_io) r_ram[w_idx] <= mem_dout;
  end

  // --------------------------------------------------------------------------
  // TX FIFO
  // --------------------------------------------------------------------------
  logic             w_tx_push;
  logic [7:0]       w_tx_wdata;
  logic             w_tx_pop;
  logic             w_tx_full;
  logic             w_tx_empty;
  logic [TX_AW:0]   w_tx_count;
  logic [TX_AW:0]   w_tx_free;

  // Zero bytes on the UART register are filtered; the stop register
  // always pushes a 0x00 terminator.
  assign w_tx_push  = w_bus_wr & w_io &
                      (((w_reg == IO_UART) && (mem_dout != 8'h00)) ||
                        (w_reg == IO_CNT0));
  assign w_tx_wdata = (w_reg == IO_CNT0) ? 8'h00 : mem_dout;
  assign w_tx_pop   = ~w_tx_empty & tx_ready;

  resp_byte_fifo #(
    .DEPTH (TX_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .i_clk   (clk_in),
    .i_rst   (rst_in),
    .i_push  (w_tx_push),
    .i_wdata (w_tx_wdata),
    .i_pop   (w_tx_pop),
    .o_rdata (tx_data),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_count)
  );

  logic w_unused_tx_full;
  assign w_unused_tx_full = w_tx_full;

  assign tx_valid       = ~w_tx_empty;
  assign w_tx_free      = c_TX_DEPTH - w_tx_count;
  assign io_buffer_full = (w_tx_free <= c_MARGIN);

  // --------------------------------------------------------------------------
  // RX FIFO
  // --------------------------------------------------------------------------
  logic       w_rx_pop;
  logic       w_rx_empty;
  logic [7:0] w_rx_head;

`ifdef IO_RX_EN
  logic                     w_rx_full;
  logic [$clog2(RX_DEPTH):0] w_unused_rx_count;

  assign w_rx_pop = w_bus_rd & w_io & (w_reg == IO_UART) & ~w_rx_empty;
  assign rx_ready = ~w_rx_full;

  resp_byte_fifo #(
    .DEPTH (RX_DEPTH),
    .WIDTH (8)
  ) u_rx_fifo (
    .i_clk   (clk_in),
    .i_rst   (rst_in),
    .i_push  (rx_valid & ~w_rx_full),
    .i_wdata (rx_data),
    .i_pop   (w_rx_pop),
    .o_rdata (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_unused_rx_count)
  );
`else
  logic w_unused_rx;

  assign w_unused_rx = ^{rx_data, rx_valid};
  assign w_rx_pop    = 1'b0;
  assign w_rx_empty  = 1'b1;
  assign w_rx_head   = 8'h00;
  assign rx_ready    = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Read data mux
  // --------------------------------------------------------------------------
  logic [31:0] r_cycle_count;
  logic [31:0] r_snapshot;
  logic [7:0]  r_mem_din;
  logic        r_prog_stop;
  logic [7:0]  w_rd_data;

  always_comb begin
    w_rd_data = 8'h00;
    if (!w_io) begin
      w_rd_data = r_ram[w_idx];
    end else begin
      case (w_reg)
        IO_UART: w_rd_data = w_rx_empty ? 8'h00 : w_rx_head;
        IO_CNT0: w_rd_data = r_cycle_count[7:0];
        IO_CNT1: w_rd_data = r_snapshot[15:8];
        IO_CNT2: w_rd_data = r_snapshot[23:16];
        IO_CNT3: w_rd_data = r_snapshot[31:24];
        default: w_rd_data = 8'h00;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Bus-side registers; all frozen while rdy_in is low.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_mem_din     <= 8'h00;
      r_cycle_count <= 32'd0;
      r_snapshot    <= 32'd0;
      r_prog_stop   <= 1'b0;
    end else if (rdy_in) begin
      r_cycle_count <= r_cycle_count + 32'd1;
      if (w_bus_rd) begin
        r_mem_din <= w_rd_data;
        // Byte 0 comes live from the counter; bytes 1..3 come from this
        // snapshot so a multi-byte readback is self-consistent.
        if (w_io && (w_reg == IO_CNT0)) r_snapshot <= r_cycle_count;
      end
      if (w_bus_wr && w_io && (w_reg == IO_CNT0)) r_prog_stop <= 1'b1;
    end
  end

  assign mem_din     = r_mem_din;
  assign cycle_count = r_cycle_count;
  assign prog_stop   = r_prog_stop;

endmodule
`default_nettype wire

// File: tb/tb_mem_io_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_io_responder
// Purpose : Self-checking bench for mem_io_responder: table-driven bus
//           vectors plus directed sequences for TX filtering, TX full,
//           counter snapshot/freeze, program stop, async reset and RX.
// Config  : IO_RX_EN selects which RX expectations apply.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_io_responder;
  import mem_io_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic [31:0] mem_a = 32'd0;
  logic [7:0]  mem_dout = 8'd0;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        prog_stop;
  logic [31:0] cycle_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] txq[$];

  mem_io_responder dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .rdy_in         (rdy),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .prog_stop      (prog_stop),
    .cycle_count    (cycle_count)
  );

  always #5 clk = ~clk;

  // Inputs only change just after posedge, so a byte seen here is
  // transferred at the following posedge.
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) txq.push_back(tx_data);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One bus cycle; returns #1 after the sampling edge.
  task automatic bus(input logic wr, input logic [31:0] a, input logic [7:0] d);
    mem_wr   = wr;
    mem_a    = a;
    mem_dout = d;
    @(posedge clk);
    #1;
    mem_wr   = 1'b0;
    mem_a    = 32'd0;
    mem_dout = 8'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) bus(1'b0, 32'd0, 8'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  dout;
    logic        chk;
    logic [7:0]  exp;
    string       name;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [7:0] exp_rx_ready;
    int bad;

    vecs[0]  = '{1'b1, 32'h0000_0010, 8'hA5, 1'b0, 8'h00, "wr_10"};
    vecs[1]  = '{1'b0, 32'h0000_0010, 8'h00, 1'b1, 8'hA5, "rd_10"};
    vecs[2]  = '{1'b1, 32'h0001_FFFF, 8'h3C, 1'b0, 8'h00, "wr_top"};
    vecs[3]  = '{1'b0, 32'h0001_FFFF, 8'h00, 1'b1, 8'h3C, "rd_top"};
    vecs[4]  = '{1'b1, 32'h0000_0000, 8'h7E, 1'b0, 8'h00, "wr_0"};
    vecs[5]  = '{1'b0, 32'h0000_0000, 8'h00, 1'b1, 8'h7E, "rd_0"};
    vecs[6]  = '{1'b0, 32'h0002_0010, 8'h00, 1'b1, 8'hA5, "rd_alias_20010"};
    vecs[7]  = '{1'b0, 32'h0003_0001, 8'h00, 1'b1, 8'h00, "rd_io_1"};
    vecs[8]  = '{1'b1, 32'h0003_0002, 8'h99, 1'b0, 8'h00, "wr_io_2"};
    vecs[9]  = '{1'b0, 32'h0003_0003, 8'h00, 1'b1, 8'h00, "rd_io_3"};
    vecs[10] = '{1'b0, c_IO_BASE,     8'h00, 1'b1, 8'h00, "rd_rx_empty"};

`ifdef IO_RX_EN
    exp_rx_ready = 8'd1;
`else
    exp_rx_ready = 8'd0;
`endif

    // ---------------- reset state ----------------
    do_reset();
    check("rst_mem_din", {24'd0, mem_din}, 32'h0);
    check("rst_buf_full", {31'd0, io_buffer_full}, 32'h0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'h0);
    check("rst_rx_ready", {31'd0, rx_ready}, {24'd0, exp_rx_ready});
    check("rst_prog_stop", {31'd0, prog_stop}, 32'h0);
    check("rst_cycle_count", cycle_count, 32'h0);

    // ---------------- table vectors ----------------
    tx_ready = 1'b1;
    foreach (vecs[i]) begin
      bus(vecs[i].wr, vecs[i].addr, vecs[i].dout);
      if (vecs[i].chk) check(vecs[i].name, {24'd0, mem_din}, {24'd0, vecs[i].exp});
    end
    check("tx_idle_after_table", {31'd0, tx_valid}, 32'h0);

    // ---------------- TX zero filtering ----------------
    txq.delete();
    bus(1'b1, 32'h0003_0000, 8'h41);
    bus(1'b1, 32'h0003_0000, 8'h00);
    bus(1'b1, 32'h0003_0000, 8'h42);
    idle(4);
    check("tx_stream_len", txq.size(), 32'd2);
    if (txq.size() == 2) begin
      check("tx_stream_0", {24'd0, txq[0]}, 32'h41);
      check("tx_stream_1", {24'd0, txq[1]}, 32'h42);
    end

    // ---------------- TX full / nearly full ----------------
    tx_ready = 1'b0;
    repeat (13) bus(1'b1, 32'h0003_0000, 8'h55);
    check("buf_full_after_13", {31'd0, io_buffer_full}, 32'h0);
    bus(1'b1, 32'h0003_0000, 8'h55);
    check("buf_full_after_14", {31'd0, io_buffer_full}, 32'h1);
    repeat (3) bus(1'b1, 32'h0003_0000, 8'h55);
    check("buf_full_after_17", {31'd0, io_buffer_full}, 32'h1);
    txq.delete();
    tx_ready = 1'b1;
    idle(20);
    check("tx_drain_len", txq.size(), 32'd16);
    bad = 0;
    foreach (txq[i]) if (txq[i] != 8'h55) bad++;
    check("tx_drain_data_bad", bad, 32'd0);
    check("tx_drained_empty", {31'd0, tx_valid}, 32'h0);
    check("buf_full_drained", {31'd0, io_buffer_full}, 32'h0);

    // ---------------- cycle counter ----------------
    do_reset();
    idle(299);
    check("cnt_after_299", cycle_count, 32'd299);
    bus(1'b0, 32'h0003_0004, 8'h00);
    check("cnt_byte0", {24'd0, mem_din}, 32'h2B);
    bus(1'b0, 32'h0003_0005, 8'h00);
    check("cnt_byte1", {24'd0, mem_din}, 32'h01);
    bus(1'b0, 32'h0003_0006, 8'h00);
    check("cnt_byte2", {24'd0, mem_din}, 32'h00);
    bus(1'b0, 32'h0003_0007, 8'h00);
    check("cnt_byte3", {24'd0, mem_din}, 32'h00);
    check("cnt_after_reads", cycle_count, 32'd303);
    bus(1'b0, 32'h0000_0010, 8'h00);
    check("ram_kept_over_reset", {24'd0, mem_din}, 32'hA5);

    rdy   = 1'b0;
    mem_a = 32'h0003_0004;
    repeat (5) @(posedge clk);
    #1;
    check("cnt_frozen", cycle_count, 32'd304);
    check("din_frozen", {24'd0, mem_din}, 32'hA5);
    rdy   = 1'b1;
    bus(1'b0, 32'h0003_0005, 8'h00);
    check("snapshot_not_retaken", {24'd0, mem_din}, 32'h01);
    check("cnt_resumed", cycle_count, 32'd305);

    // ---------------- program stop ----------------
    txq.delete();
    check("prog_stop_before", {31'd0, prog_stop}, 32'h0);
    bus(1'b1, 32'h0003_0004, 8'h00);
    check("prog_stop_set", {31'd0, prog_stop}, 32'h1);
    idle(3);
    check("stop_tx_len", txq.size(), 32'd1);
    if (txq.size() == 1) check("stop_tx_byte", {24'd0, txq[0]}, 32'h00);
    check("prog_stop_sticky", {31'd0, prog_stop}, 32'h1);

    // ---------------- async reset mid-stream ----------------
    tx_ready = 1'b0;
    repeat (3) bus(1'b1, 32'h0003_0000, 8'h77);
    check("tx_pending", {31'd0, tx_valid}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_prog_stop", {31'd0, prog_stop}, 32'h0);
    check("async_rst_tx_valid", {31'd0, tx_valid}, 32'h0);
    check("async_rst_cnt", cycle_count, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tx_ready = 1'b1;

    // ---------------- RX path ----------------
    check("rx_ready_idle", {31'd0, rx_ready}, {24'd0, exp_rx_ready});
    rx_data  = 8'h31;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    bus(1'b0, 32'h0003_0000, 8'h00);
`ifdef IO_RX_EN
    check("rx_read_1", {24'd0, mem_din}, 32'h31);
`else
    check("rx_read_1", {24'd0, mem_din}, 32'h00);
`endif
    bus(1'b0, 32'h0003_0000, 8'h00);
    check("rx_read_2", {24'd0, mem_din}, 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
Memory-side responder for the CPU's byte-wide memory bus (mem_a / mem_dout / mem_wr / mem_din / io_buffer_full). It models the 128 KB RAM with one-cycle read latency and single-cycle writes. It also implements the memory-mapped I/O at mem_a[17:16]==2'b11:
- UART TX and RX byte FIFOs
- cycle-counter readback
- program-stop flag
The block sits in the simulation/FPGA top, opposite the CPU's memory controller.

Parameters:
ADDR_WIDTH, 17, RAM byte-address width (2^17 bytes)
TX_DEPTH, 16, TX FIFO entries (power of 2)
RX_DEPTH, 16, RX FIFO entries (power of 2)
FULL_MARGIN, 2, free TX entries at or below which io_buffer_full asserts

Ports:
clk_in  in  1  clock; single clock domain
rst_in  in  1  reset, asynchronous, active-high
rdy_in  in  1  global ready; low freezes all bus-side state
mem_a  in  32  byte address from CPU
mem_dout  in  8  write data from CPU
mem_wr  in  1  1 = write, 0 = read
mem_din  out  8  read data to CPU, valid the cycle after the read
io_buffer_full  out  1  TX FIFO nearly full
tx_data  out  8  UART TX byte (FIFO head)
tx_valid  out  1  TX FIFO non-empty
tx_ready  in  1  UART accepts byte
rx_data  in  8  UART RX byte
rx_valid  in  1  RX byte offered
rx_ready  out  1  RX FIFO not full
prog_stop  out  1  sticky: program wrote 0x30004
cycle_count  out  32  cycles with rdy_in high since reset

Behaviour:
- Reset values: mem_din=0, io_buffer_full=0, tx_valid=0, rx_ready=1, prog_stop=0, cycle_count=0, snapshot=0, both FIFOs empty. RAM contents are not reset (preloaded).
- Address decode:
  - io = (mem_a[17:16]==2'b11).
  - RAM index = mem_a[ADDR_WIDTH-1:0].
  - I/O register = mem_a[2:0] (0x0 = UART, 0x4..0x7 = counter).
- All bus actions occur only when rdy_in=1. When rdy_in=0: no writes, no FIFO push/pop from the bus, mem_din holds, cycle_count holds.
- RAM write (mem_wr=1, !io): ram[idx] <= mem_dout at the edge. A read of the same address in the following cycle returns the new value.
- Read (mem_wr=0): mem_din is registered at the edge and visible next cycle. Every cycle with mem_wr=0 is a read.
  - RAM: ram[idx].
  - 0x30000: RX head, and pops RX. If RX is empty, returns 0x00 with no pop.
  - 0x30004: latches snapshot<=cycle_count and returns cycle_count[7:0].
  - 0x30005..0x30007: return snapshot bytes 1..3.
  - Other I/O addresses: 0x00.
- Write 0x30000:
  - If mem_dout≠0, push to TX.
  - 0x00 is ignored.
  - Push is accepted if TX is not full or a TX pop occurs in the same cycle; otherwise the byte is dropped.
- Write 0x30004: prog_stop<=1 (sticky until reset) and push 0x00 into TX under the same acceptance rule.
- Writes to other I/O addresses are ignored.
- TX drain: tx_valid = TX non-empty. tx_data = head. Pop on tx_valid & tx_ready. Drain is independent of rdy_in.
- RX fill: rx_ready = RX count < RX_DEPTH. Push on rx_valid & rx_ready, independent of rdy_in. A simultaneous RX push and bus pop is legal; count is unchanged.
- io_buffer_full = (TX_DEPTH − tx_count) ≤ FULL_MARGIN, computed from the registered count.
- cycle_count increments on every rdy_in-high cycle and wraps modulo 2^32.
- FIFO pointers are log2(depth)+1 bits. Full/empty are derived from MSB compare. Wrap-around is transparent.

Optional Feature:
IO_RX_EN:
- Defined: RX FIFO and the rx_* handshake are implemented as above.
- Undefined: no RX FIFO. rx_ready ties to 0, rx_data/rx_valid are ignored, and reads of 0x30000 return 0x00 with no side effect.

Decomposition:
- Shared package (def.v style macros): IO base 0x30000, UART offset 0x0, counter offset 0x4, RAM size, I/O decode bits [17:16].
- One natural sub-module, resp_byte_fifo: parameterized depth; push/pop/full/empty/count; instantiated for TX and for RX.

Test Plan:
- Write 0xA5 to 0x00010, read 0x00010 next cycle -> mem_din=0xA5 one cycle after the read.
- Write 0x41, 0x00, 0x42 to 0x30000 with tx_ready=1 -> tx_data stream 0x41, 0x42 only; no 0x00 emitted.
- tx_ready=0, 14 writes of 0x55 to 0x30000 -> io_buffer_full rises after the 14th; 17th write dropped; tx_count=16.
- After 100 rdy_in cycles, read 0x30004..0x30007 -> bytes form snapshot ≥100, consistent across all four reads; rdy_in low for 5 cycles freezes cycle_count.
- Write 0x00 to 0x30004 -> prog_stop=1 next cycle, TX emits 0x00; assert rst_in mid-stream -> prog_stop=0 and FIFOs empty immediately.
- IO_RX_EN defined: rx_valid with 0x31 then read 0x30000 -> mem_din=0x31; second read returns 0x00.
